// File: rtl/soc_sysid_pkg.sv
// Shared constants for the system-ID / uptime register slave: register map,
// CTRL bit positions and counter width.
package soc_sysid_pkg;

  localparam int UPTIME_W = 64;
  localparam int DATA_W   = 32;

  localparam logic [2:0] OFF_ID        = 3'd0;
  localparam logic [2:0] OFF_TIMESTAMP = 3'd1;
  localparam logic [2:0] OFF_UPTIME_LO = 3'd2;
  localparam logic [2:0] OFF_UPTIME_HI = 3'd3;
  localparam logic [2:0] OFF_SCRATCH   = 3'd4;
  localparam logic [2:0] OFF_CTRL      = 3'd5;
  localparam logic [2:0] OFF_PRESCALE  = 3'd6;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

endpackage

// File: rtl/soc_sysid_regs_if.sv
// Avalon-MM slave bus bundle (no waitrequest) for the system-ID register block.
interface soc_sysid_regs_if;

  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Prescaled 64-bit free-running uptime counter with synchronous clear and freeze.
module sysid_uptime_counter
  import soc_sysid_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                freeze,
  output logic [UPTIME_W-1:0] uptime
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_TERM = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     ps_q;
  logic [UPTIME_W-1:0] uptime_q;

  // Clear has priority over a coincident terminal count and over freeze.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      ps_q     <= '0;
      uptime_q <= '0;
    end else if (!freeze) begin
      if (ps_q == PS_TERM) begin
        ps_q     <= '0;
        uptime_q <= uptime_q + UPTIME_W'(1);
      end else begin
        ps_q <= ps_q + PS_W'(1);
      end
    end
  end

  assign uptime = uptime_q;

endmodule

// File: rtl/soc_sysid_regs.sv
// System-ID / uptime register slave: register decode, uptime snapshot shadow,
// scratch and control registers, and a fixed-latency pipelined read path.
module soc_sysid_regs
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID        = 32'h0,
  parameter logic [31:0] TIMESTAMP     = 32'h0,
  parameter int          PRESCALE      = 50,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
  input  logic             clock,
  input  logic             reset,
  soc_sysid_regs_if.slave  bus
);

  logic                rd_en;
  logic                wr_en;
  logic                clear;
  logic [UPTIME_W-1:0] uptime;
  logic [31:0]         shadow_q;
  logic [31:0]         scratch_q;
  logic                freeze_q;
  logic [31:0]         rd_mux;

  // A simultaneous read and write performs the read and drops the write.
  assign rd_en = bus.read;
  assign wr_en = bus.write && !bus.read;
  assign clear = wr_en && (bus.address == OFF_CTRL) && bus.writedata[CTRL_CLEAR];

  sysid_uptime_counter #(
    .PRESCALE (PRESCALE)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .freeze (freeze_q),
    .uptime (uptime)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q  <= '0;
      scratch_q <= SCRATCH_RESET;
      freeze_q  <= 1'b0;
    end else begin
      if (rd_en && (bus.address == OFF_UPTIME_LO))
        shadow_q <= uptime[UPTIME_W-1:32];
      if (wr_en && (bus.address == OFF_SCRATCH))
        scratch_q <= bus.writedata;
      if (wr_en && (bus.address == OFF_CTRL))
        freeze_q <= bus.writedata[CTRL_FREEZE];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      OFF_ID:        rd_mux = SYS_ID;
      OFF_TIMESTAMP: rd_mux = TIMESTAMP;
      OFF_UPTIME_LO: rd_mux = uptime[31:0];
      OFF_UPTIME_HI: rd_mux = shadow_q;
      OFF_SCRATCH:   rd_mux = scratch_q;
      OFF_CTRL:      rd_mux[CTRL_FREEZE] = freeze_q;
      OFF_PRESCALE:  rd_mux = 32'(PRESCALE);
      default:       rd_mux = '0;
    endcase
  end

  logic [READ_LATENCY-1:0]       rd_vld_p;
  logic [READ_LATENCY-1:0][31:0] rd_data_p;

  // Stage 0 captures the decode; later stages only delay. Data is zeroed when not valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld_p  <= '0;
      rd_data_p <= '0;
    end else begin
      rd_vld_p[0]  <= rd_en;
      rd_data_p[0] <= rd_en ? rd_mux : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_p[i]  <= rd_vld_p[i-1];
        rd_data_p[i] <= rd_data_p[i-1];
      end
    end
  end

  assign bus.readdata      = rd_data_p[READ_LATENCY-1];
  assign bus.readdatavalid = rd_vld_p[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_sysid_regs.sv
// Bench for soc_sysid_regs: two instances (PRESCALE=1/latency 2, PRESCALE=50/latency 1)
// share one bus stimulus and are compared against a tick-count reference model.
module tb_soc_sysid_regs;

  localparam logic [31:0] SYS_ID  = 32'h5802_0C4C;
  localparam logic [31:0] TSTAMP  = 32'h6650_1234;
  localparam logic [31:0] SCR_RST = 32'hA5A5_0001;
  localparam int PS_A = 1;
  localparam int RL_A = 2;
  localparam int PS_B = 50;
  localparam int RL_B = 1;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;

  soc_sysid_regs_if bus_a ();
  soc_sysid_regs_if bus_b ();

  assign bus_a.address   = address;
  assign bus_a.read      = read;
  assign bus_a.write     = write;
  assign bus_a.writedata = writedata;
  assign bus_b.address   = address;
  assign bus_b.read      = read;
  assign bus_b.write     = write;
  assign bus_b.writedata = writedata;

  soc_sysid_regs #(
    .SYS_ID (SYS_ID), .TIMESTAMP (TSTAMP), .PRESCALE (PS_A),
    .READ_LATENCY (RL_A), .SCRATCH_RESET (SCR_RST)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  soc_sysid_regs #(
    .SYS_ID (SYS_ID), .TIMESTAMP (TSTAMP), .PRESCALE (PS_B),
    .READ_LATENCY (RL_B), .SCRATCH_RESET (SCR_RST)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: uptime is derived from the number of unfrozen clock edges
  // since the last reset/clear, divided by the prescale value.
  logic [63:0] ticks;
  logic        m_freeze;
  logic [31:0] m_scratch;
  logic [31:0] sh_a;
  logic [31:0] sh_b;
  bit          force_active = 1'b0;
  logic [63:0] force_ticks  = 64'd0;

  function automatic logic [63:0] up_a();
    if (force_active) return 64'hFFFF_FFFF + (ticks - force_ticks);
    return ticks / 64'(PS_A);
  endfunction

  function automatic logic [63:0] up_b();
    return ticks / 64'(PS_B);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      ticks     <= 64'd0;
      m_freeze  <= 1'b0;
      m_scratch <= SCR_RST;
      sh_a      <= 32'd0;
      sh_b      <= 32'd0;
    end else begin
      if (read && address == 3'd2) begin
        sh_a <= 32'(up_a() >> 32);
        sh_b <= 32'(up_b() >> 32);
      end
      if (write && !read && address == 3'd4) m_scratch <= writedata;
      if (write && !read && address == 3'd5) m_freeze <= writedata[1];
      if (write && !read && address == 3'd5 && writedata[0]) ticks <= 64'd0;
      else if (!m_freeze) ticks <= ticks + 64'd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] a, input bit is_b);
    logic [63:0] u;
    u = is_b ? up_b() : up_a();
    case (a)
      3'd0:    return SYS_ID;
      3'd1:    return TSTAMP;
      3'd2:    return u[31:0];
      3'd3:    return is_b ? sh_b : sh_a;
      3'd4:    return m_scratch;
      3'd5:    return {30'd0, m_freeze, 1'b0};
      3'd6:    return is_b ? 32'(PS_B) : 32'(PS_A);
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one bus cycle, advance one clock, then check both DUT outputs.
  task automatic cycle(input bit rd, input bit wr, input logic [2:0] a,
                       input logic [31:0] wd, input bit rst = 1'b0);
    exp_t e;
    read = rd; write = wr; address = a; writedata = wd; reset = rst;
    if (rd && !rst) begin
      qa.push_back('{cyc + RL_A, exp_rd(a, 1'b0)});
      qb.push_back('{cyc + RL_B, exp_rd(a, 1'b1)});
    end
    @(posedge clock);
    #1;
    cyc++;
    if (rst) begin
      qa.delete();
      qb.delete();
      force_active = 1'b0;
    end else if (wr && !rd && a == 3'd5 && wd[0]) begin
      force_active = 1'b0;
    end
    read = 1'b0; write = 1'b0; reset = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      chk("a_rdv", 32'(bus_a.readdatavalid), 32'd1);
      chk("a_rdata", bus_a.readdata, e.d);
    end else begin
      chk("a_rdv_idle", 32'(bus_a.readdatavalid), 32'd0);
      chk("a_rdata_idle", bus_a.readdata, 32'd0);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      chk("b_rdv", 32'(bus_b.readdatavalid), 32'd1);
      chk("b_rdata", bus_b.readdata, e.d);
    end else begin
      chk("b_rdv_idle", 32'(bus_b.readdatavalid), 32'd0);
      chk("b_rdata_idle", bus_b.readdata, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);

    // Reset values, all offsets back to back
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 3'(k), 32'd0);
    idle(3);

    // Uptime after long idle periods (PRESCALE 1 and 50)
    idle(1000);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    cycle(1'b1, 1'b0, 3'd3, 32'd0);
    idle(4000);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    idle(3);

    // Scratch write then four pipelined reads
    cycle(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 3'd4, 32'd0);
    idle(3);

    // Writes to read-only offsets are ignored; read+write drops the write
    cycle(1'b0, 1'b1, 3'd0, 32'h1234_5678);
    cycle(1'b0, 1'b1, 3'd6, 32'h1234_5678);
    cycle(1'b0, 1'b1, 3'd7, 32'h1234_5678);
    cycle(1'b1, 1'b1, 3'd4, 32'h0BAD_F00D);
    cycle(1'b1, 1'b0, 3'd4, 32'd0);
    cycle(1'b1, 1'b0, 3'd0, 32'd0);
    cycle(1'b1, 1'b0, 3'd6, 32'd0);
    cycle(1'b1, 1'b0, 3'd7, 32'd0);
    idle(3);

    // Clear+freeze: counter zeroed and held, CTRL reads 2, then resume
    cycle(1'b0, 1'b1, 3'd5, 32'd3);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    idle(200);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    cycle(1'b1, 1'b0, 3'd5, 32'd0);
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    idle(120);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    cycle(1'b1, 1'b0, 3'd5, 32'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 7);
      cycle(op < 4 || op == 7, op >= 4, 3'($urandom_range(0, 7)), $urandom);
    end
    idle(3);

    // Snapshot across a 32-bit carry: counter preloaded to FFFF_FFFF while frozen
    cycle(1'b0, 1'b1, 3'd5, 32'd2);
    idle(2);
    force dut_a.u_counter.uptime_q = 64'h0000_0000_FFFF_FFFF;
    force_ticks  = ticks;
    force_active = 1'b1;
    idle(1);
    release dut_a.u_counter.uptime_q;
    idle(1);
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    idle(10);
    cycle(1'b1, 1'b0, 3'd3, 32'd0);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    cycle(1'b1, 1'b0, 3'd3, 32'd0);
    idle(3);

    // Plain clear while running
    idle(37);
    cycle(1'b0, 1'b1, 3'd5, 32'd1);
    cycle(1'b1, 1'b0, 3'd2, 32'd0);
    idle(3);

    // Reset mid-operation: pending results discarded, state restored
    cycle(1'b0, 1'b1, 3'd4, 32'h7777_0000);
    cycle(1'b0, 1'b1, 3'd5, 32'd2);
    cycle(1'b1, 1'b0, 3'd4, 32'd0);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    idle(3);
    cycle(1'b0, 1'b1, 3'd4, 32'h7777_0001);
    cycle(1'b1, 1'b0, 3'd2, 32'd0, 1'b1);
    idle(3);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 3'(k), 32'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_sysid_regs.md
# soc_sysid_regs

Parametrised system-identification and uptime register slave for the SoC's Avalon-MM fabric. It extends the fixed ID/timestamp slave with a prescaled 64-bit uptime counter with atomic high/low readout, a scratch register, a control register, and a pipelined read path with `readdatavalid`. Software uses it to confirm the loaded bitstream, time events, and sanity-check bus access.

## Interface
Parameters:
- `SYS_ID`, 32'h0, system ID returned at offset 0
- `TIMESTAMP`, 32'h0, build timestamp returned at offset 1
- `PRESCALE`, 50, clocks per uptime increment; legal range ≥1
- `READ_LATENCY`, 1, read data latency in cycles; legal values 1 or 2
- `SCRATCH_RESET`, 32'h0, scratch register reset value

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `address`  in  3  word address
- `read`  in  1  read strobe
- `write`  in  1  write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  read data, valid when `readdatavalid`=1
- `readdatavalid`  out  1  one-cycle pulse per accepted read

## Operation
- Register map, by word offset:
  - 0: `SYS_ID`, RO
  - 1: `TIMESTAMP`, RO
  - 2: `UPTIME_LO`, RO. A read also latches `uptime[63:32]` into the shadow register.
  - 3: `UPTIME_HI`, RO. Returns the shadow register, not the live counter.
  - 4: `SCRATCH`, RW, full 32 bits
  - 5: `CTRL`
    - bit0 `CLEAR`: write 1 to zero the counter and prescaler. Self-clearing; always reads 0.
    - bit1 `FREEZE`: RW; while 1, counting halts.
    - Other bits read 0.
  - 6: `PRESCALE` value, RO
  - 7: reads 0
- Writes to RO offsets and to offset 7 are ignored.
- No `waitrequest`. Every read and every write is accepted in the cycle it is presented.
- Prescaler:
  - Counts 0..`PRESCALE`-1 while not frozen.
  - On the terminal count it wraps to 0 and the 64-bit `uptime` increments by 1.
  - With `PRESCALE`=1, `uptime` increments every cycle.
- `uptime` wraps from 2^64-1 to 0 with no flag.

## Timing
- Reset values:
  - `readdata`=0, `readdatavalid`=0
  - `uptime`=0, prescaler=0, shadow=0
  - `SCRATCH`=`SCRATCH_RESET`, `FREEZE`=0
- Read issued in cycle N:
  - `readdatavalid`=1 and `readdata` valid in cycle N+`READ_LATENCY`.
  - The data reflects register state sampled in cycle N, before any update made in cycle N.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
  - When `readdatavalid`=0, `readdata` is 0.
- Snapshot: reading `UPTIME_LO` in cycle N returns `uptime[31:0]` at N and latches `uptime[63:32]` at N. A later `UPTIME_HI` read returns exactly that value, regardless of carries in between.
- Writes take effect at the clock edge ending the write cycle. A read in the next cycle sees the new value.
- `read` and `write` asserted together: the read is performed and the write is dropped.
- `CLEAR` coincident with a prescaler terminal count: clear wins, and `uptime`=0 in the following cycle.
- `CLEAR` and `FREEZE`=1 written in the same word: the counter is zeroed and then stays frozen at 0.
- Reset asserted mid-operation: pending read results in the pipeline are discarded, with no `readdatavalid` pulses after reset. All state returns to its reset values on the next edge.

## Structure
- Package `soc_sysid_pkg` holds:
  - register offset constants `OFF_ID` … `OFF_PRESCALE`
  - `CTRL` bit indices `CTRL_CLEAR`=0, `CTRL_FREEZE`=1
  - `UPTIME_W`=64
- Sub-module `sysid_uptime_counter` contains the prescaler and the 64-bit counter.
  - Inputs: `clear`, `freeze`.
  - Output: `uptime`.
- The top level holds the register decode, the shadow register, `SCRATCH`, `CTRL`, and the read pipeline, which is a `READ_LATENCY`-deep valid/data shift register.

## Test plan
- After reset: read offsets 0, 1, 4, 5, 6 with `SYS_ID`=32'h5802_0C4C and `PRESCALE`=50 → 32'h5802_0C4C, `TIMESTAMP`, `SCRATCH_RESET`, 0, 50. Each arrives exactly `READ_LATENCY` cycles later.
- `PRESCALE`=1: hold for 1000 cycles, then read `UPTIME_LO` → 1000 ± the fixed pipeline offset. Repeat with `PRESCALE`=50 over 5000 cycles → 100.
- Force `uptime` to 32'hFFFF_FFFF, read `LO`, wait 10 cycles, read `HI` → `LO`=FFFF_FFFF and `HI`=0. The carry is not seen until the next `LO` read.
- Write `SCRATCH`=32'hDEAD_BEEF, then read it back-to-back 4 times → 4 consecutive `readdatavalid` pulses, all DEAD_BEEF.
- Write `CTRL`=3 → `uptime` reads 0 and stays 0 for 200 cycles. Write `CTRL`=0 → counting resumes. `CTRL` reads 2 while frozen.
- Issue a read, assert `reset` in cycle N+`READ_LATENCY`-1 → no `readdatavalid` is produced, and all registers hold their reset values.
